// File: rtl/snake_nav_ctrl.sv
// Multi-player snake direction controller: per-player button conditioning,
// perpendicular-turn filtering and a small turn FIFO drained one entry per TICK.
module snake_nav_ctrl #(
    parameter int         NUM_PLAYERS     = 1,
    parameter int         QUEUE_DEPTH     = 2,
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter logic [1:0] INIT_DIR        = 2'b00
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic [4*NUM_PLAYERS-1:0] PUSH_BUTTONS,
    input  logic                     TICK,
    input  logic                     CLEAR,
    output logic [2*NUM_PLAYERS-1:0] DIR_OUT,
    output logic [NUM_PLAYERS-1:0]   DIR_CHANGED,
    output logic [NUM_PLAYERS-1:0]   PENDING,
    output logic [NUM_PLAYERS-1:0]   TURN_DROPPED
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [3:0]    sync1, sync2, deb, deb_d, press;
        logic [DW-1:0] deb_cnt [4];
        logic [1:0]    fifo [QUEUE_DEPTH];
        logic [PW-1:0] rd_ptr, wr_ptr, tail_ptr;
        logic [CW-1:0] count, count_after_pop;
        logic [1:0]    dir_q, req_dir, ref_dir, head;
        logic          req_valid, pop, legal, full, push;
        logic          changed_q, dropped_q;

        // Button conditioning is never touched by CLEAR; only its events are discarded.
        always_ff @(posedge CLOCK or negedge RESET) begin
            if (!RESET) begin
                sync1 <= '0;
                sync2 <= '0;
                deb   <= '0;
                deb_d <= '0;
                press <= '0;
                for (int b = 0; b < 4; b++) deb_cnt[b] <= '0;
            end else begin
                sync1 <= PUSH_BUTTONS[4*p +: 4];
                sync2 <= sync1;
                deb_d <= deb;
                press <= deb & ~deb_d;
                for (int b = 0; b < 4; b++) begin
                    if (sync2[b] == deb[b]) begin
                        deb_cnt[b] <= '0;
                    end else if (deb_cnt[b] == DW'(DEBOUNCE_CYCLES - 1)) begin
                        deb[b]     <= sync2[b];
                        deb_cnt[b] <= '0;
                    end else begin
                        deb_cnt[b] <= deb_cnt[b] + DW'(1);
                    end
                end
            end
        end

        always_comb begin
            req_valid = |press;
            req_dir   = 2'b00;
            if (press[0])      req_dir = 2'b00;
            else if (press[1]) req_dir = 2'b01;
            else if (press[2]) req_dir = 2'b10;
            else if (press[3]) req_dir = 2'b11;

            pop             = TICK && (count != '0);
            count_after_pop = count - CW'(pop);
            head            = fifo[rd_ptr];
            tail_ptr        = (wr_ptr == '0) ? PW'(QUEUE_DEPTH - 1) : wr_ptr - PW'(1);

            // With an empty queue, compare against the direction DIR_OUT is about
            // to hold, so a same-cycle pop can never enable a queued reversal.
            if (count_after_pop != '0) ref_dir = fifo[tail_ptr];
            else if (pop)              ref_dir = head;
            else                       ref_dir = dir_q;

            // Horizontal directions have equal bits, vertical ones differ.
            legal = req_valid && ((req_dir[1] ^ req_dir[0]) != (ref_dir[1] ^ ref_dir[0]));
            full  = (count_after_pop == CW'(QUEUE_DEPTH));
            push  = legal && !full;
        end

        always_ff @(posedge CLOCK or negedge RESET) begin
            if (!RESET) begin
                dir_q     <= INIT_DIR;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                changed_q <= 1'b0;
                dropped_q <= 1'b0;
                for (int i = 0; i < QUEUE_DEPTH; i++) fifo[i] <= 2'b00;
            end else if (CLEAR) begin
                dir_q     <= INIT_DIR;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                changed_q <= 1'b0;
                dropped_q <= 1'b0;
            end else begin
                changed_q <= pop && (head != dir_q);
                dropped_q <= legal && full;
                count     <= count_after_pop + CW'(push);
                if (pop) begin
                    dir_q  <= head;
                    rd_ptr <= (rd_ptr == PW'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
                end
                if (push) begin
                    fifo[wr_ptr] <= req_dir;
                    wr_ptr       <= (wr_ptr == PW'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
                end
            end
        end

        assign DIR_OUT[2*p +: 2] = dir_q;
        assign DIR_CHANGED[p]    = changed_q;
        assign PENDING[p]        = (count != '0);
        assign TURN_DROPPED[p]   = dropped_q;
    end

endmodule

// File: tb/tb_snake_nav_ctrl.sv
// Bench for snake_nav_ctrl: directed scenarios plus a random run checked
// against a queue-based reference model of the player controllers.
module tb_snake_nav_ctrl;
    localparam int NP = 2;
    localparam int QD = 2;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] btn = 8'h00;
    logic [3:0] dir_out;
    logic [1:0] dir_chg, pend, drop;

    int n_tests = 0;
    int n_fail  = 0;
    int drop_seen [NP];
    int chg_seen  [NP];

    always #5 clk = ~clk;

    snake_nav_ctrl #(
        .NUM_PLAYERS(NP), .QUEUE_DEPTH(QD), .DEBOUNCE_CYCLES(DB), .INIT_DIR(2'b00)
    ) dut (
        .CLOCK(clk), .RESET(rst_n), .PUSH_BUTTONS(btn), .TICK(tick), .CLEAR(clr),
        .DIR_OUT(dir_out), .DIR_CHANGED(dir_chg), .PENDING(pend), .TURN_DROPPED(drop)
    );

    // Reference model: button levels and events per button, turns held in queues.
    bit       m_s1 [8], m_s2 [8], m_deb [8], m_debp [8], m_evt [8];
    int       m_cnt [8];
    bit [1:0] m_dir [NP];
    bit       m_chg [NP], m_drp [NP];
    bit [1:0] mq [NP][$];
    int       m_req;
    bit [1:0] m_ref, m_nd;

    function automatic bit horiz(input bit [1:0] d);
        return (d == 2'b00) || (d == 2'b11);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 8; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_debp[b] = 0; m_evt[b] = 0; m_cnt[b] = 0;
            end
            for (int p = 0; p < NP; p++) begin
                m_dir[p] = 2'b00; m_chg[p] = 0; m_drp[p] = 0; mq[p].delete();
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                m_req = -1;
                for (int b = 3; b >= 0; b--) if (m_evt[4*p+b]) m_req = b;
                m_chg[p] = 0;
                m_drp[p] = 0;
                if (clr) begin
                    m_dir[p] = 2'b00;
                    mq[p].delete();
                end else begin
                    if (tick && mq[p].size() > 0) begin
                        m_nd     = mq[p].pop_front();
                        m_chg[p] = (m_nd != m_dir[p]);
                        m_dir[p] = m_nd;
                    end
                    m_ref = (mq[p].size() > 0) ? mq[p][mq[p].size()-1] : m_dir[p];
                    if (m_req >= 0 && horiz(2'(m_req)) != horiz(m_ref)) begin
                        if (mq[p].size() >= QD) m_drp[p] = 1;
                        else mq[p].push_back(2'(m_req));
                    end
                end
            end
            for (int b = 0; b < 8; b++) begin
                m_evt[b]  = m_deb[b] && !m_debp[b];
                m_debp[b] = m_deb[b];
                if (m_s2[b] == m_deb[b]) m_cnt[b] = 0;
                else if (m_cnt[b] == DB - 1) begin
                    m_deb[b] = m_s2[b];
                    m_cnt[b] = 0;
                end else m_cnt[b] = m_cnt[b] + 1;
                m_s2[b] = m_s1[b];
                m_s1[b] = btn[b];
            end
        end
    end

    function automatic logic [9:0] exp_vec();
        return {m_dir[1], m_dir[0], m_chg[1], m_chg[0],
                mq[1].size() != 0, mq[0].size() != 0, m_drp[1], m_drp[0]};
    endfunction

    task automatic do_clear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic tick_once();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Holds the buttons 6 cycles, releases, and lets both edges settle.
    task automatic press(input int p, input logic [3:0] bits);
        for (int q = 0; q < NP; q++) begin drop_seen[q] = 0; chg_seen[q] = 0; end
        btn[4*p +: 4] = bits;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            for (int q = 0; q < NP; q++) begin
                drop_seen[q] += int'(drop[q]);
                chg_seen[q]  += int'(dir_chg[q]);
            end
            if (i == 5) btn[4*p +: 4] = 4'b0000;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({dir_out, dir_chg, pend, drop} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected %b", {dir_out, dir_chg, pend, drop}, 10'b0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (dir_out !== 4'b0000 || pend !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release: got dir %b pend %b expected 0000 00", dir_out, pend);
        end
    endtask

    task automatic test_press_latency();
        do_clear();
        btn[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (pend[0] !== 1'(i >= 7)) begin
                n_fail++;
                $display("FAIL press_latency edge+%0d: got pending %b expected %b", i, pend[0], i >= 7);
            end
        end
        btn[1] = 1'b0;
        repeat (3) @(negedge clk);
        tick_once();
        n_tests++;
        if (dir_out[1:0] !== 2'b01 || dir_chg[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL first_tick: got dir %b chg %b expected 01 1", dir_out[1:0], dir_chg[0]);
        end
        chg_seen[0] = 0;
        repeat (10) begin
            @(negedge clk);
            chg_seen[0] += int'(dir_chg[0]);
        end
        n_tests++;
        if (chg_seen[0] !== 0) begin
            n_fail++;
            $display("FAIL single_pulse: got %0d extra pulses expected 0", chg_seen[0]);
        end
    endtask

    task automatic test_bounce();
        do_clear();
        for (int i = 0; i < 12; i++) begin
            btn[2] = ((i / 2) % 2) == 0;
            @(negedge clk);
        end
        btn[2] = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (pend[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce: got pending %b expected 0", pend[0]);
        end
        btn[2] = 1'b1;
        repeat (3) @(negedge clk);
        btn[2] = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++;
        if (pend[0] !== 1'b0 || dir_out !== 4'b0000) begin
            n_fail++;
            $display("FAIL short_hold: got pending %b dir %b expected 0 0000", pend[0], dir_out);
        end
    endtask

    task automatic test_reversal();
        do_clear();
        press(0, 4'b1000);
        n_tests++;
        if (pend[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reversal_left: got pending %b expected 0", pend[0]);
        end
        press(0, 4'b0100);
        press(0, 4'b0010);
        tick_once();
        n_tests++;
        if (dir_out[1:0] !== 2'b10 || pend[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reversal_tail: got dir %b pending %b expected 10 0", dir_out[1:0], pend[0]);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        press(0, 4'b0010);
        press(0, 4'b1000);
        press(0, 4'b0100);
        n_tests++;
        if (drop_seen[0] !== 1 || pend[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_drop: got %0d drop pulses pending %b expected 1 1", drop_seen[0], pend[0]);
        end
        tick_once();
        n_tests++;
        if (dir_out[1:0] !== 2'b01) begin
            n_fail++;
            $display("FAIL overflow_tick1: got %b expected 01", dir_out[1:0]);
        end
        tick_once();
        n_tests++;
        if (dir_out[1:0] !== 2'b11 || pend[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_tick2: got dir %b pending %b expected 11 0", dir_out[1:0], pend[0]);
        end
    endtask

    task automatic test_simultaneous();
        do_clear();
        btn = 8'b0100_0010;
        repeat (7) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        btn  = 8'h00;
        n_tests++;
        if (dir_out !== 4'b0000 || dir_chg !== 2'b00 || pend !== 2'b11) begin
            n_fail++;
            $display("FAIL tick_with_push: got dir %b chg %b pend %b expected 0000 00 11", dir_out, dir_chg, pend);
        end
        repeat (2) @(negedge clk);
        tick_once();
        n_tests++;
        if (dir_out !== 4'b1001 || dir_chg !== 2'b11 || pend !== 2'b00) begin
            n_fail++;
            $display("FAIL both_players: got dir %b chg %b pend %b expected 1001 11 00", dir_out, dir_chg, pend);
        end
        repeat (10) @(negedge clk);
        do_clear();
        press(0, 4'b0110);
        tick_once();
        n_tests++;
        if (dir_out[1:0] !== 2'b01) begin
            n_fail++;
            $display("FAIL lowest_bit_wins: got %b expected 01", dir_out[1:0]);
        end
    endtask

    task automatic test_clear_reset();
        do_clear();
        press(0, 4'b0010);
        press(0, 4'b1000);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_tests++;
        if (dir_out !== 4'b0000 || pend !== 2'b00) begin
            n_fail++;
            $display("FAIL clear_full: got dir %b pend %b expected 0000 00", dir_out, pend);
        end
        press(0, 4'b0010);
        tick_once();
        press(0, 4'b1000);
        n_tests++;
        if (dir_out[1:0] !== 2'b01 || pend[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: got dir %b pending %b expected 01 1", dir_out[1:0], pend[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (dir_out !== 4'b0000 || pend !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset: got dir %b pend %b expected 0000 00", dir_out, pend);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (dir_out !== 4'b0000 || pend !== 2'b00) begin
            n_fail++;
            $display("FAIL after_reset: got dir %b pend %b expected 0000 00", dir_out, pend);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            n_tests++;
            if ({dir_out, dir_chg, pend, drop} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %b expected %b", i, {dir_out, dir_chg, pend, drop}, exp_vec());
            end
            for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
            tick = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 79) == 0);
            @(negedge clk);
        end
        btn  = 8'h00;
        tick = 1'b0;
        clr  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_bounce();
        test_reversal();
        test_overflow();
        test_simultaneous();
        test_clear_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
